// File: rtl/commit_rat.sv
// Commit-stage register alias table: it holds the retired arch-to-phys map and
// queues the superseded physical registers so the freelist can reclaim them.
module commit_rat #(
  parameter int NUM_ARCH     = 32,
  parameter int NUM_PHYS     = 64,
  parameter int COMMIT_W     = 2,
  parameter int FREE_Q_DEPTH = 8,
  localparam int AW = $clog2(NUM_ARCH),
  localparam int PW = $clog2(NUM_PHYS),
  localparam int CW = $clog2(FREE_Q_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [COMMIT_W-1:0]              commit_valid_i,
  input  logic [COMMIT_W-1:0][AW-1:0]      commit_rd_i,
  input  logic [COMMIT_W-1:0][PW-1:0]      commit_pd_i,
  output logic                             commit_ready_o,
  output logic                             free_valid_o,
  output logic [PW-1:0]                    free_pd_o,
  input  logic                             free_ready_i,
  output logic [NUM_ARCH-1:0][PW-1:0]      arch_map_o,
  output logic [CW-1:0]                    free_count_o
);

  localparam int QW = (CW > 1) ? CW - 1 : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(FREE_Q_DEPTH - COMMIT_W);

  logic [NUM_ARCH-1:0][PW-1:0] arch_map_q, arch_map_d;
  logic [PW-1:0]               mem_q [FREE_Q_DEPTH];
  logic [QW-1:0]               head_q, tail_q;
  logic [CW-1:0]               count_q, count_d;
  logic [CW-1:0]               enq_cnt;
  logic [PW-1:0]               enq_pd [COMMIT_W];
  logic                        deq;

  // Room is judged on registered occupancy only; a same-cycle pop earns no credit.
  assign commit_ready_o = (count_q <= MAX_CNT);
  assign free_valid_o   = (count_q != '0);
  assign free_pd_o      = mem_q[head_q];
  assign free_count_o   = count_q;
  assign arch_map_o     = arch_map_q;
  assign deq            = free_valid_o && free_ready_i;

  // Walking lanes oldest-first through a running copy of the map makes a
  // younger lane with the same rd reclaim the older lane's pd automatically.
  always_comb begin
    arch_map_d = arch_map_q;
    enq_cnt    = '0;
    for (int k = 0; k < COMMIT_W; k++) enq_pd[k] = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_ready_o && commit_valid_i[i] && (commit_rd_i[i] != '0)) begin
        enq_pd[enq_cnt]            = arch_map_d[commit_rd_i[i]];
        arch_map_d[commit_rd_i[i]] = commit_pd_i[i];
        enq_cnt                    = enq_cnt + CW'(1);
      end
    end
    arch_map_d[0] = '0;
    count_d = count_q + enq_cnt - CW'(deq);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) arch_map_q[i] <= PW'(i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      arch_map_q <= arch_map_d;
      tail_q     <= tail_q + QW'(enq_cnt);
      head_q     <= head_q + QW'(deq);
      count_q    <= count_d;
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < COMMIT_W; k++) begin
      if (CW'(k) < enq_cnt) mem_q[tail_q + QW'(k)] <= enq_pd[k];
    end
  end

endmodule

// File: tb/tb_commit_rat.sv
// Directed bench for commit_rat: map updates, reclaim ordering, backpressure,
// FIFO wrap and reset override, all against hand-computed values.
module tb_commit_rat;

  localparam int NUM_ARCH = 32;
  localparam int PW       = 6;
  localparam int AW       = 5;
  localparam int CW       = 4;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [1:0]                  commit_valid;
  logic [1:0][AW-1:0]          commit_rd;
  logic [1:0][PW-1:0]          commit_pd;
  logic                        commit_ready;
  logic                        free_valid;
  logic [PW-1:0]               free_pd;
  logic                        free_ready;
  logic [NUM_ARCH-1:0][PW-1:0] arch_map;
  logic [CW-1:0]               free_count;

  int checks = 0;
  int errors = 0;

  commit_rat dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid_i (commit_valid),
    .commit_rd_i    (commit_rd),
    .commit_pd_i    (commit_pd),
    .commit_ready_o (commit_ready),
    .free_valid_o   (free_valid),
    .free_pd_o      (free_pd),
    .free_ready_i   (free_ready),
    .arch_map_o     (arch_map),
    .free_count_o   (free_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [1:0] v, input int rd0, input int pd0,
                        input int rd1, input int pd1);
    commit_valid = v;
    commit_rd[0] = AW'(rd0);
    commit_pd[0] = PW'(pd0);
    commit_rd[1] = AW'(rd1);
    commit_pd[1] = PW'(pd1);
    tick();
    commit_valid = 2'b00;
  endtask

  task automatic pop_expect(input string tag, input int exp);
    check(tag, 32'(free_pd), 32'(exp));
    free_ready = 1'b1;
    tick();
    free_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    commit_valid = '0;
    commit_rd = '0;
    commit_pd = '0;
    free_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_free_valid", 32'(free_valid), 0);
    check("rst_count", 32'(free_count), 0);
    check("rst_ready", 32'(commit_ready), 1);
    check("rst_map5", 32'(arch_map[5]), 5);
    check("rst_map31", 32'(arch_map[31]), 31);

    // single lane
    commit(2'b01, 5, 40, 0, 0);
    check("l0_map5", 32'(arch_map[5]), 40);
    check("l0_free_valid", 32'(free_valid), 1);
    check("l0_free_pd", 32'(free_pd), 5);
    check("l0_count", 32'(free_count), 1);

    // same-rd collision in one group
    commit(2'b11, 7, 33, 7, 34);
    check("coll_map7", 32'(arch_map[7]), 34);
    check("coll_count", 32'(free_count), 3);

    // x0 lane ignored
    commit(2'b11, 0, 50, 3, 51);
    check("x0_map0", 32'(arch_map[0]), 0);
    check("x0_map3", 32'(arch_map[3]), 51);
    check("x0_count", 32'(free_count), 4);

    pop_expect("pop_a0", 5);
    pop_expect("pop_a1", 7);
    pop_expect("pop_a2", 33);
    pop_expect("pop_a3", 3);
    check("drain_count", 32'(free_count), 0);
    check("drain_valid", 32'(free_valid), 0);

    // free_ready on an empty queue does nothing
    free_ready = 1'b1;
    tick();
    free_ready = 1'b0;
    check("empty_pop_count", 32'(free_count), 0);

    // fill to 7 with pops held off
    commit(2'b01, 1, 41, 0, 0);
    commit(2'b11, 2, 42, 4, 43);
    commit(2'b11, 6, 44, 8, 45);
    check("fill_ready5", 32'(commit_ready), 1);
    commit(2'b11, 9, 46, 10, 47);
    check("full_count", 32'(free_count), 7);
    check("full_ready", 32'(commit_ready), 0);
    commit(2'b11, 11, 48, 12, 49);
    check("blocked_map11", 32'(arch_map[11]), 11);
    check("blocked_map12", 32'(arch_map[12]), 12);
    check("blocked_count", 32'(free_count), 7);
    pop_expect("pop_b0", 1);
    check("unblock_count", 32'(free_count), 6);
    check("unblock_ready", 32'(commit_ready), 1);

    pop_expect("pop_b1", 2);
    pop_expect("pop_b2", 4);
    check("steady_count", 32'(free_count), 4);

    // commit and pop in the same cycle
    check("simul_head", 32'(free_pd), 6);
    free_ready = 1'b1;
    commit(2'b11, 13, 50, 14, 51);
    free_ready = 1'b0;
    check("simul_count", 32'(free_count), 5);
    check("simul_map13", 32'(arch_map[13]), 50);

    // drain across pointer wrap
    pop_expect("wrap0", 8);
    pop_expect("wrap1", 9);
    pop_expect("wrap2", 10);
    pop_expect("wrap3", 13);
    pop_expect("wrap4", 14);
    check("wrap_count", 32'(free_count), 0);

    // refill to 5 then reset mid-stream with a commit and pop offered
    commit(2'b01, 15, 52, 0, 0);
    commit(2'b11, 16, 53, 17, 54);
    commit(2'b11, 18, 55, 19, 56);
    check("pre_rst_count", 32'(free_count), 5);
    check("pre_rst_map15", 32'(arch_map[15]), 52);
    rst = 1'b1;
    free_ready = 1'b1;
    commit(2'b11, 20, 57, 21, 58);
    rst = 1'b0;
    free_ready = 1'b0;
    check("rst2_valid", 32'(free_valid), 0);
    check("rst2_count", 32'(free_count), 0);
    check("rst2_ready", 32'(commit_ready), 1);
    check("rst2_map15", 32'(arch_map[15]), 15);
    check("rst2_map20", 32'(arch_map[20]), 20);
    check("rst2_map7", 32'(arch_map[7]), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/commit_rat.md
COMMIT_RAT -- requirements
Module: commit_rat

Interface
- REQ-001: Parameter NUM_ARCH, default 32, number of architectural registers; index 0 is hardwired x0.
- REQ-002: Parameter NUM_PHYS, default 64, number of physical registers.
- REQ-003: Parameter COMMIT_W, default 2, commit lanes per cycle; lane 0 is oldest.
- REQ-004: Parameter FREE_Q_DEPTH, default 8, power of two, SHALL be >= COMMIT_W.
- REQ-005: Derived widths: AW = $clog2(NUM_ARCH), PW = $clog2(NUM_PHYS), CW = $clog2(FREE_Q_DEPTH)+1.
- REQ-006: clk  input  1  clock; all state updates on rising edge.
- REQ-007: rst  input  1  reset, synchronous, active-high.
- REQ-008: commit_valid  input  [COMMIT_W]  per-lane retiring instruction writes a register.
- REQ-009: commit_rd  input  [COMMIT_W][AW]  per-lane architectural destination.
- REQ-010: commit_pd  input  [COMMIT_W][PW]  per-lane physical destination.
- REQ-011: commit_ready  output  1  commit group accepted this cycle.
- REQ-012: free_valid  output  1  free queue head holds a reclaimed physical register.
- REQ-013: free_pd  output  PW  head of free queue.
- REQ-014: free_ready  input  1  freelist pops head this cycle.
- REQ-015: arch_map  output  [NUM_ARCH][PW]  committed arch-to-phys map, for flush recovery.
- REQ-016: free_count  output  CW  current free-queue occupancy.

Function
- REQ-017: commit_ready SHALL be 1 iff FREE_Q_DEPTH - free_count >= COMMIT_W, using registered occupancy (dequeue in the same cycle not credited).
- REQ-018: Group accepted iff commit_ready=1; when commit_ready=0 all lanes SHALL be ignored (no partial commit, no map change, no enqueue).
- REQ-019: Lane is active iff commit_valid=1, commit_rd!=0 and group accepted; inactive lanes have no effect.
- REQ-020: For each active lane, the previous mapping of commit_rd SHALL be enqueued as reclaimed; previous mapping = arch_map value at start of cycle, or pd of the nearest older active lane in the same group with the same rd.
- REQ-021: Same-rd collision within a group: youngest active lane's pd SHALL be written to arch_map; every older lane's pd is reclaimed by the next younger lane per REQ-020.
- REQ-022: Enqueue order SHALL be lane order (lane 0 first); 0..COMMIT_W entries per cycle.
- REQ-023: arch_map update visible one cycle after acceptance; arch_map[0] SHALL always equal 0.
- REQ-024: Dequeue occurs iff free_valid && free_ready; free_pd SHALL be the oldest entry; free_valid = (free_count != 0).
- REQ-025: Enqueued entries appear on free_pd no earlier than the cycle after acceptance (no bypass).
- REQ-026: Simultaneous enqueue and dequeue SHALL both take effect; free_count' = free_count + enq - deq.
- REQ-027: Head/tail pointers wrap modulo FREE_Q_DEPTH; queue SHALL never overflow or underflow.
- REQ-028: free_ready while free_valid=0 SHALL have no effect.

Reset
- REQ-029: On rst, arch_map[i] SHALL be i for all i, queue emptied, free_count=0, free_valid=0, commit_ready=1 on the following cycle.
- REQ-030: rst overrides any same-cycle commit or dequeue; queued reclaims are discarded.

Verification
- REQ-031: After reset, lane0 rd=5 pd=40 -> next cycle arch_map[5]=40, free_valid=1, free_pd=5, free_count=1.
- REQ-032: Same cycle lane0 rd=7 pd=33, lane1 rd=7 pd=34 -> arch_map[7]=34; queue receives 7 then 33.
- REQ-033: Lane0 rd=0 pd=50, lane1 rd=3 pd=51 -> arch_map[0]=0, arch_map[3]=51, only 3 enqueued.
- REQ-034: Hold free_ready=0, commit 2 lanes/cycle until free_count=7 -> commit_ready=0; group offered ignored (map unchanged); raise free_ready one cycle -> free_count=6, commit_ready=1.
- REQ-035: free_count=4 steady, 2-lane commit with free_ready=1 -> free_count=5; pops in FIFO order across pointer wrap.
- REQ-036: Assert rst with free_count=5 mid-stream -> next cycle free_valid=0, arch_map identity, commit_ready=1.
